uart_rx_edge_bit_sampler: RTL and testbench

Oversampling timebase and data sampler for the UART receiver. Inputs: synchronised RX line and the prescale value from the receiver FSM. Produces the per-bit edge counter, the frame bit counter, and a majority-voted sampled bit. Consumers are the start, parity, stop and deserializer stages. Those stages read `Sampled_Bit` once `Edge_Cnt` reaches `(Prescale >> 1) + 2`.

---
 rtl/uart_rx_edge_bit_sampler.sv | 109 ++++++++++
 tb/tb_uart_rx_edge_bit_sampler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_edge_bit_sampler.sv
// Oversampling timebase and majority-vote data sampler for the UART receiver.
// Tracks the position inside the current bit (Edge_Cnt) and the bit index
// inside the frame (Bit_Cnt), and produces a 3-sample majority-voted bit
// taken around the bit centre. Enable is the only mode control: while it is
// low the counters and sample registers are held clear, while Sampled_Bit
// keeps its last value.
// There is no handshake on this block; downstream stages read Sampled_Bit
// once Edge_Cnt reaches (Prescale >> 1) + 2 and use Bit_Done/Frame_Done as
// single-cycle strobes in the last cycle of a bit/frame.
module uart_rx_edge_bit_sampler #(
    parameter int FRAME_BITS = 11
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Enable,
    input  logic       RX_IN,
    input  logic [7:0] Prescale,
    output logic [7:0] Edge_Cnt,
    output logic [3:0] Bit_Cnt,
    output logic       Sampled_Bit,
    output logic       Bit_Done,
    output logic       Frame_Done
);

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic [7:0] r_edge_cnt;
    logic [3:0] r_bit_cnt;
    logic       r_s0;
    logic       r_s1;
    logic       r_sampled;

    logic [7:0] w_half;
    logic [7:0] w_last_edge;
    logic [7:0] w_s0_edge;
    logic [7:0] w_vote_edge;
    logic       w_edge_wrap;
    logic       w_bit_wrap;
    logic       w_vote;

    // H = floor(Prescale/2); the three samples straddle the bit centre.
    assign w_half      = {1'b0, Prescale[7:1]};
    assign w_last_edge = Prescale - 8'd1;
    assign w_s0_edge   = w_half - 8'd1;
    assign w_vote_edge = w_half + 8'd1;
    assign w_edge_wrap = (r_edge_cnt == w_last_edge);
    assign w_bit_wrap  = (r_bit_cnt == LAST_BIT);

    // Third vote is the live synchronised line, taken in the H+1 cycle.
    assign w_vote = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RX_IN;
            r_sync2 <= r_sync1;
        end
    end

    // Edge and bit counters; bit counter advances only when the edge counter wraps.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_edge_cnt <= 8'd0;
            r_bit_cnt  <= 4'd0;
        end else if (!Enable) begin
            r_edge_cnt <= 8'd0;
            r_bit_cnt  <= 4'd0;
        end else if (w_edge_wrap) begin
            r_edge_cnt <= 8'd0;
            r_bit_cnt  <= w_bit_wrap ? 4'd0 : r_bit_cnt + 4'd1;
        end else begin
            r_edge_cnt <= r_edge_cnt + 8'd1;
        end
    end

    // Capture two samples at H-1 and H, vote at H+1; dropping Enable cancels a pending vote.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s0      <= 1'b0;
            r_s1      <= 1'b0;
            r_sampled <= 1'b1;
        end else if (!Enable) begin
            r_s0      <= 1'b0;
            r_s1      <= 1'b0;
        end else begin
            if (r_edge_cnt == w_s0_edge) begin
                r_s0 <= r_sync2;
            end
            if (r_edge_cnt == w_half) begin
                r_s1 <= r_sync2;
            end
            if (r_edge_cnt == w_vote_edge) begin
                r_sampled <= w_vote;
            end
        end
    end

    assign Edge_Cnt    = r_edge_cnt;
    assign Bit_Cnt     = r_bit_cnt;
    assign Sampled_Bit = r_sampled;
    assign Bit_Done    = Enable & w_edge_wrap;
    assign Frame_Done  = Bit_Done & w_bit_wrap;

endmodule

// File: tb/tb_uart_rx_edge_bit_sampler.sv
// Self-checking bench for uart_rx_edge_bit_sampler. Expected output vectors
// {Edge_Cnt, Bit_Cnt, Sampled_Bit, Bit_Done, Frame_Done} are derived from the
// cycle index within a frame and a per-bit sample pattern, queued as the
// stimulus is driven and compared after the clock edge.
module tb_uart_rx_edge_bit_sampler;

    localparam int FRAME_BITS = 11;

    logic       CLK;
    logic       RST;
    logic       Enable;
    logic       RX_IN;
    logic [7:0] Prescale;
    logic [7:0] Edge_Cnt;
    logic [3:0] Bit_Cnt;
    logic       Sampled_Bit;
    logic       Bit_Done;
    logic       Frame_Done;

    logic [14:0] exp_q[$];
    int          n_vec;
    int          n_err;
    logic        exp_sb;

    // Per-bit values of rx_s at edges H-1, H, H+1 (index 0,1,2); bits
    // beyond npat see an idle-high line.
    logic [2:0]  pat [0:15];
    int          npat;

    uart_rx_edge_bit_sampler #(.FRAME_BITS(FRAME_BITS)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Enable      (Enable),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .Edge_Cnt    (Edge_Cnt),
        .Bit_Cnt     (Bit_Cnt),
        .Sampled_Bit (Sampled_Bit),
        .Bit_Done    (Bit_Done),
        .Frame_Done  (Frame_Done)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic maj3(input logic [2:0] p);
        return (p[0] & p[1]) | (p[0] & p[2]) | (p[1] & p[2]);
    endfunction

    function automatic logic [2:0] pat_for(input int k);
        if (k < npat) return pat[k];
        return 3'b111;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] e, input logic [3:0] b, input logic s,
                            input logic bd, input logic fd);
        exp_q.push_back({e, b, s, bd, fd});
    endtask

    task automatic pop_check(input string tag);
        logic [14:0] exp;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
            return;
        end
        exp = exp_q.pop_front();
        check_eq(tag, {17'd0, Edge_Cnt, Bit_Cnt, Sampled_Bit, Bit_Done, Frame_Done},
                 {17'd0, exp});
    endtask

    // Runs ncyc enabled cycles from a cleared state with prescale p,
    // driving RX_IN so that rx_s follows the pattern table.
    task automatic run_frame(input string tag, input int p, input int ncyc);
        int h;
        int t;
        int te;
        int tb;
        int e;
        int b;
        logic [2:0] tp;
        logic bd;
        logic fd;
        h = p / 2;
        Prescale = 8'(p);
        Enable = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            t  = i + 2;
            te = t % p;
            tb = t / p;
            tp = pat_for(tb);
            if (te >= h - 1 && te <= h + 1) RX_IN = tp[te - (h - 1)];
            else RX_IN = maj3(tp);
            e = i % p;
            b = (i / p) % FRAME_BITS;
            if (e == h + 2) exp_sb = maj3(pat_for(i / p));
            bd = (e == p - 1);
            fd = bd && (b == FRAME_BITS - 1);
            push_exp(8'(e), 4'(b), exp_sb, bd, fd);
            #2;
            pop_check(tag);
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic disable_check(input string tag);
        Enable = 1'b0;
        push_exp(8'd0, 4'd0, exp_sb, 1'b0, 1'b0);
        @(posedge CLK);
        #3;
        pop_check(tag);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        npat     = 0;
        exp_sb   = 1'b1;
        RST      = 1'b1;
        Enable   = 1'b1;
        RX_IN    = 1'b0;
        Prescale = 8'd8;

        // Reset dominates Enable and a low line
        repeat (3) begin
            push_exp(8'd0, 4'd0, 1'b1, 1'b0, 1'b0);
            @(posedge CLK);
            #3;
            pop_check("reset");
        end

        // Idle after reset release
        RST    = 1'b0;
        Enable = 1'b0;
        RX_IN  = 1'b1;
        repeat (3) begin
            push_exp(8'd0, 4'd0, 1'b1, 1'b0, 1'b0);
            @(posedge CLK);
            #3;
            pop_check("idle");
        end

        // Full frame of counting, including the wrap back to 0/0
        npat = 0;
        run_frame("count", 8, 89);
        disable_check("count_off");

        // Majority vote patterns 0,1,0 / 1,0,1 / 0,0,1
        pat[0] = 3'b010;
        pat[1] = 3'b101;
        pat[2] = 3'b100;
        npat = 3;
        run_frame("majority", 8, 32);
        disable_check("majority_off");

        // Start bit: line low before Enable rises
        RX_IN = 1'b0;
        repeat (2) begin
            push_exp(8'd0, 4'd0, exp_sb, 1'b0, 1'b0);
            @(posedge CLK);
            #3;
            pop_check("pre_start");
        end
        pat[0] = 3'b000;
        npat = 1;
        run_frame("start", 16, 20);
        disable_check("start_off");

        // Odd prescale: H=4, wrap after edge 8
        pat[0] = 3'b001;
        pat[1] = 3'b011;
        npat = 2;
        run_frame("odd", 9, 27);
        disable_check("odd_off");

        // Enable dropped at Edge_Cnt=4, Bit_Cnt=3: pending vote of 1 is lost
        pat[0] = 3'b000;
        pat[1] = 3'b000;
        pat[2] = 3'b000;
        pat[3] = 3'b111;
        npat = 4;
        run_frame("abort_run", 8, 28);
        Enable = 1'b0;
        push_exp(8'd4, 4'd3, exp_sb, 1'b0, 1'b0);
        #2;
        pop_check("abort_now");
        push_exp(8'd0, 4'd0, exp_sb, 1'b0, 1'b0);
        @(posedge CLK);
        #3;
        pop_check("abort_clr");
        push_exp(8'd0, 4'd0, exp_sb, 1'b0, 1'b0);
        @(posedge CLK);
        #3;
        pop_check("abort_hold");

        // Reset at the same point: Sampled_Bit returns to 1
        run_frame("rst_run", 8, 28);
        RST = 1'b1;
        push_exp(8'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        @(posedge CLK);
        #3;
        pop_check("rst_mid");
        exp_sb = 1'b1;
        RST    = 1'b0;
        Enable = 1'b0;
        push_exp(8'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        @(posedge CLK);
        #3;
        pop_check("rst_after");

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
